// File: rtl/baud_gen_frac_if.sv
// Control/status bundle for the fractional baud generator.
// master = controller side (drives divisor/enable), slave = generator side.
interface baud_gen_frac_if #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4,
    parameter int unsigned OSR    = 16
);
    localparam int unsigned PH_W = $clog2(OSR);

    logic              en;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_wr;
    logic              sync_clr;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic [PH_W-1:0]   os_phase;
    logic              cfg_pending;

    modport master (
        output en, div_int, div_frac, div_wr, sync_clr,
        input  os_tick, mid_tick, bit_tick, os_phase, cfg_pending
    );

    modport slave (
        input  en, div_int, div_frac, div_wr, sync_clr,
        output os_tick, mid_tick, bit_tick, os_phase, cfg_pending
    );
endinterface

// File: rtl/baud_gen_frac.sv
// Fractional-N oversample/bit tick generator with shadowed divisor updates.
// Define BAUD_GEN_FRAC_EN to include the fractional accumulator (integer-only otherwise).
module baud_gen_frac #(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned FRAC_W    = 4,
    parameter int unsigned OSR       = 16,
    parameter int unsigned RESET_DIV = 0
) (
    input logic            clk,
    input logic            Reset_n,
    baud_gen_frac_if.slave bus
);
    localparam int unsigned PH_W = $clog2(OSR);

    logic [DIV_W:0]   cnt_q, cnt_d, limit;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic             os_q, os_d, mid_q, mid_d, bit_q, bit_d;
    logic             pend_q, pend_d;
    logic [DIV_W-1:0] act_int_q, act_int_d, shd_int_q, shd_int_d;
    logic             ext_q;
    logic             boundary, apply;

`ifdef BAUD_GEN_FRAC_EN
    logic              ext_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d, shd_frac_q, shd_frac_d;
`else
    logic unused_div_frac;
    assign ext_q           = 1'b0;
    assign unused_div_frac = ^bus.div_frac;
`endif

    // The stored carry stretches the current period by one cycle.
    assign limit    = {1'b0, act_int_q} + {{DIV_W{1'b0}}, ext_q};
    assign boundary = bus.en && !bus.sync_clr && (cnt_q == limit);
    assign apply    = pend_q && (!bus.en || boundary);

    always_comb begin
        cnt_d   = cnt_q + (DIV_W+1)'(1);
        phase_d = phase_q;
        os_d    = 1'b0;
        mid_d   = 1'b0;
        bit_d   = 1'b0;
        if (!bus.en || bus.sync_clr) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (boundary) begin
            cnt_d   = '0;
            os_d    = 1'b1;
            mid_d   = (phase_q == PH_W'(OSR/2 - 1));
            bit_d   = (phase_q == PH_W'(OSR - 1));
            phase_d = phase_q + PH_W'(1);
        end
        act_int_d = apply ? shd_int_q : act_int_q;
        shd_int_d = bus.div_wr ? bus.div_int : shd_int_q;
        // A write coinciding with an apply re-arms pending for the new value.
        pend_d    = bus.div_wr || (pend_q && !apply);
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q     <= '0;
            phase_q   <= '0;
            os_q      <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
            pend_q    <= 1'b0;
            act_int_q <= DIV_W'(RESET_DIV);
            shd_int_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            os_q      <= os_d;
            mid_q     <= mid_d;
            bit_q     <= bit_d;
            pend_q    <= pend_d;
            act_int_q <= act_int_d;
            shd_int_q <= shd_int_d;
        end
    end

`ifdef BAUD_GEN_FRAC_EN
    always_comb begin
        {ext_d, acc_d} = {ext_q, acc_q};
        if (!bus.en || apply) begin
            {ext_d, acc_d} = '0;
        end else if (boundary) begin
            {ext_d, acc_d} = {1'b0, acc_q} + {1'b0, act_frac_q};
        end
        act_frac_d = apply ? shd_frac_q : act_frac_q;
        shd_frac_d = bus.div_wr ? bus.div_frac : shd_frac_q;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_q      <= 1'b0;
            acc_q      <= '0;
            act_frac_q <= '0;
            shd_frac_q <= '0;
        end else begin
            ext_q      <= ext_d;
            acc_q      <= acc_d;
            act_frac_q <= act_frac_d;
            shd_frac_q <= shd_frac_d;
        end
    end
`endif

    assign bus.os_tick     = os_q;
    assign bus.mid_tick    = mid_q;
    assign bus.bit_tick    = bit_q;
    assign bus.os_phase    = phase_q;
    assign bus.cfg_pending = pend_q;
endmodule
